dram_read_arbiter: RTL and testbench

Two-requester arbiter for the single DRAM read-command port: kick/busy/read_num/read_addr plus the returning buf_dout/buf_we stream. It sits between the DRAM read engine and two stream blocks, for example two frame-copy/filter pipelines. Each requester sees a private copy of the same port and behaves unchanged. Grants are round-robin, one burst at a time. The block adds a start timeout and a returned-word-count check.

---
 rtl/dram_read_arbiter_if.sv | 31 +++
 rtl/dram_read_arbiter.sv | 128 ++++++++++++
 tb/tb_dram_read_arbiter.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dram_read_arbiter_if.sv
// Bus bundle for the shared DRAM read-command port: the two requester-side
// copies of kick/busy/num/addr/data and the single DRAM-side port.
interface dram_read_arbiter_if;
  // Handshake: a requester holds req_kick[i] high until it sees req_busy[i]
  // high; the arbiter holds kick high until the engine raises busy, and a
  // burst is complete when busy falls. Data words move on each *_we pulse.
  logic [1:0]  req_kick;
  logic [31:0] req_num0;
  logic [31:0] req_num1;
  logic [31:0] req_addr0;
  logic [31:0] req_addr1;
  logic [1:0]  req_busy;
  logic [31:0] req_dout;
  logic [1:0]  req_we;
  logic        kick;
  logic        busy;
  logic [31:0] read_num;
  logic [31:0] read_addr;
  logic [31:0] buf_dout;
  logic        buf_we;

  modport slave (
    input  req_kick, req_num0, req_num1, req_addr0, req_addr1, busy, buf_dout, buf_we,
    output req_busy, req_dout, req_we, kick, read_num, read_addr
  );

  modport master (
    output req_kick, req_num0, req_num1, req_addr0, req_addr1, busy, buf_dout, buf_we,
    input  req_busy, req_dout, req_we, kick, read_num, read_addr
  );
endinterface

// File: rtl/dram_read_arbiter.sv
// Round-robin arbiter sharing one DRAM read-command port between two
// requesters, with a start timeout and a returned-word-count check.
module dram_read_arbiter #(
  parameter logic [15:0] TIMEOUT = 16'd4096
) (
  input  logic                      CLK,
  input  logic                      RST,
  dram_read_arbiter_if.slave        bus,
  output logic [1:0]                grant,
  output logic [1:0]                err,
  input  logic                      ERR_CLR,
  output logic [1:0]                dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_XFER    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  grant_d;
  logic        last_g_q, last_g_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] num_q, num_d;
  logic [31:0] cnt_q, cnt_d;
  logic [15:0] tmo_q, tmo_d;
  logic [1:0]  err_d;
  logic        kick_q;
  logic [1:0]  req_busy_q;
  logic        active;
  logic        routed;
  logic        pick1;

  // Strobes only reach the owner while a burst is actually in flight.
  assign active        = (state_q == S_ISSUE) || (state_q == S_XFER);
  assign routed        = bus.buf_we & active;
  assign bus.req_we    = {2{routed}} & grant;
  assign bus.req_dout  = bus.buf_dout;
  assign bus.kick      = kick_q;
  assign bus.req_busy  = req_busy_q;
  assign bus.read_addr = addr_q;
  assign bus.read_num  = num_q;
  assign dbg_state     = state_q;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant;
    last_g_d = last_g_q;
    addr_d   = addr_q;
    num_d    = num_q;
    tmo_d    = tmo_q;
    cnt_d    = cnt_q;
    pick1    = 1'b0;
    // A fresh error is OR-ed in after the clear, so it survives a same-cycle clear.
    err_d    = ERR_CLR ? 2'b00 : err;

    if (routed && (cnt_q != 32'hFFFF_FFFF)) cnt_d = cnt_q + 32'd1;
    if (bus.buf_we && !active) err_d[1] = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (bus.req_kick != 2'b00) begin
          pick1   = (bus.req_kick == 2'b10) || ((bus.req_kick == 2'b11) && !last_g_q);
          grant_d = pick1 ? 2'b10 : 2'b01;
          addr_d  = pick1 ? bus.req_addr1 : bus.req_addr0;
          num_d   = pick1 ? bus.req_num1 : bus.req_num0;
          cnt_d   = 32'd0;
          tmo_d   = 16'd0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (bus.busy) begin
          state_d = S_XFER;
        end else if (tmo_q == 16'(TIMEOUT - 16'd1)) begin
          err_d[0] = 1'b1;
          state_d  = S_RELEASE;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      S_XFER: begin
        if (!bus.busy) begin
          if (cnt_d != num_q) err_d[1] = 1'b1;
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        last_g_d = grant[1];
        grant_d  = 2'b00;
        state_d  = S_IDLE;
      end
      default: begin
        grant_d = 2'b00;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      grant      <= 2'b00;
      last_g_q   <= 1'b1;
      addr_q     <= 32'd0;
      num_q      <= 32'd0;
      cnt_q      <= 32'd0;
      tmo_q      <= 16'd0;
      err        <= 2'b00;
      kick_q     <= 1'b0;
      req_busy_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      grant      <= grant_d;
      last_g_q   <= last_g_d;
      addr_q     <= addr_d;
      num_q      <= num_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      err        <= err_d;
      kick_q     <= (state_d == S_ISSUE);
      req_busy_q <= grant_d & {2{(state_d == S_ISSUE) || (state_d == S_XFER)}};
    end
  end

endmodule

// File: tb/tb_dram_read_arbiter.sv
// Bench for dram_read_arbiter: directed bursts with a DRAM model; routed data
// words are checked by a negedge monitor against an expected queue.
module tb_dram_read_arbiter;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       err_clr = 1'b0;
  logic [1:0] grant;
  logic [1:0] err;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [33:0] exp_q[$];

  dram_read_arbiter_if bus ();

  dram_read_arbiter #(.TIMEOUT(16'd16)) dut (
    .CLK       (clk),
    .RST       (rst),
    .bus       (bus),
    .grant     (grant),
    .err       (err),
    .ERR_CLR   (err_clr),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every routed strobe must match the head of the expected queue.
  always @(negedge clk) begin
    logic [33:0] e;
    if (!rst) check("grant_not_11", {63'd0, grant == 2'b11}, 64'd0);
    if (bus.req_we != 2'b00) begin
      if (exp_q.size() == 0) begin
        check("unexpected_req_we", {62'd0, bus.req_we}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("route_we_data", {30'd0, bus.req_we, bus.req_dout}, {30'd0, e});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_kick();
    int waited = 0;
    while (!bus.kick && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("kick_seen", {63'd0, bus.kick}, 64'd1);
  endtask

  task automatic clear_err();
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    @(negedge clk);
    check("err_cleared", {62'd0, err}, 64'd0);
  endtask

  // DRAM model serving one burst; returns at the RELEASE-cycle negedge.
  task automatic serve(input int owner, input logic [31:0] addr, input logic [31:0] num,
                       input int n_strobes, input logic [1:0] exp_err);
    logic [1:0] oh;
    oh = (owner == 1) ? 2'b10 : 2'b01;
    wait_kick();
    check("grant_owner", {62'd0, grant}, {62'd0, oh});
    check("read_addr", {32'd0, bus.read_addr}, {32'd0, addr});
    check("read_num", {32'd0, bus.read_num}, {32'd0, num});
    check("req_busy_issue", {62'd0, bus.req_busy}, {62'd0, oh});
    bus.req_kick[owner] = 1'b0;
    repeat (2) @(posedge clk);
    #1 bus.busy = 1'b1;
    for (int i = 0; i < n_strobes; i++) begin
      @(posedge clk);
      #1 bus.buf_we = 1'b1;
      bus.buf_dout = addr ^ 32'(i);
      exp_q.push_back({oh, addr ^ 32'(i)});
    end
    @(posedge clk);
    #1 bus.buf_we = 1'b0;
    bus.busy = 1'b0;
    @(negedge clk);
    check("req_busy_hold", {62'd0, bus.req_busy}, {62'd0, oh});
    @(posedge clk);
    @(negedge clk);
    check("req_busy_fall", {62'd0, bus.req_busy}, 64'd0);
    check("state_release", {62'd0, dbg_state}, {62'd0, ST_RELEASE});
    check("err_after_burst", {62'd0, err}, {62'd0, exp_err});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_kick"}, {63'd0, bus.kick}, 64'd0);
    check({tag, "_read_num"}, {32'd0, bus.read_num}, 64'd0);
    check({tag, "_read_addr"}, {32'd0, bus.read_addr}, 64'd0);
    check({tag, "_req_busy"}, {62'd0, bus.req_busy}, 64'd0);
    check({tag, "_req_we"}, {62'd0, bus.req_we}, 64'd0);
    check({tag, "_grant"}, {62'd0, grant}, 64'd0);
    check({tag, "_err"}, {62'd0, err}, 64'd0);
    check({tag, "_state"}, {62'd0, dbg_state}, {62'd0, ST_IDLE});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n_issue;
    bus.req_kick  = 2'b00;
    bus.req_num0  = 32'd0;
    bus.req_num1  = 32'd0;
    bus.req_addr0 = 32'd0;
    bus.req_addr1 = 32'd0;
    bus.busy      = 1'b0;
    bus.buf_dout  = 32'd0;
    bus.buf_we    = 1'b0;
    do_reset();
    @(negedge clk);
    check_reset_outputs("reset");

    // Single requester, 64-word burst.
    @(posedge clk);
    #1 bus.req_addr0 = 32'h100;
    bus.req_num0 = 32'd64;
    bus.req_kick = 2'b01;
    @(negedge clk);
    check("kick_not_same_cycle", {63'd0, bus.kick}, 64'd0);
    @(negedge clk);
    check("kick_one_cycle_later", {63'd0, bus.kick}, 64'd1);
    serve(0, 32'h100, 32'd64, 64, 2'b00);
    @(negedge clk);
    check("single_back_idle", {62'd0, dbg_state}, {62'd0, ST_IDLE});
    check("single_grant_clear", {62'd0, grant}, 64'd0);

    // Contention straight after reset: 0, then 1, then 0 again.
    do_reset();
    @(posedge clk);
    #1 bus.req_addr0 = 32'h2000;
    bus.req_num0  = 32'd8;
    bus.req_addr1 = 32'h3000;
    bus.req_num1  = 32'd5;
    bus.req_kick  = 2'b11;
    serve(0, 32'h2000, 32'd8, 8, 2'b00);
    bus.req_addr0 = 32'h4000;
    bus.req_num0  = 32'd4;
    bus.req_kick[0] = 1'b1;
    serve(1, 32'h3000, 32'd5, 5, 2'b00);
    serve(0, 32'h4000, 32'd4, 4, 2'b00);

    // Word mismatch: 63 strobes for a 64-word request.
    @(negedge clk);
    bus.req_addr0 = 32'h8000;
    bus.req_num0  = 32'd64;
    bus.req_kick  = 2'b01;
    serve(0, 32'h8000, 32'd64, 63, 2'b10);
    clear_err();

    // Stray strobe while idle, then clear colliding with another stray strobe.
    @(posedge clk);
    #1 bus.buf_we = 1'b1;
    bus.buf_dout = 32'hDEAD_BEEF;
    @(posedge clk);
    #1 bus.buf_we = 1'b0;
    @(negedge clk);
    check("stray_err", {62'd0, err}, 64'd2);
    @(posedge clk);
    #1 bus.buf_we = 1'b1;
    err_clr = 1'b1;
    @(posedge clk);
    #1 bus.buf_we = 1'b0;
    err_clr = 1'b0;
    @(negedge clk);
    check("err_wins_over_clr", {62'd0, err}, 64'd2);
    clear_err();

    // Start timeout: busy never rises.
    @(posedge clk);
    #1 bus.req_addr0 = 32'h9000;
    bus.req_num0 = 32'd16;
    bus.req_kick = 2'b01;
    wait_kick();
    bus.req_kick = 2'b00;
    n_issue = 0;
    while (dbg_state == ST_ISSUE && n_issue < 40) begin
      n_issue++;
      @(negedge clk);
    end
    check("timeout_issue_cycles", 64'(n_issue), 64'd16);
    check("timeout_release", {62'd0, dbg_state}, {62'd0, ST_RELEASE});
    check("timeout_err", {62'd0, err}, 64'd1);
    check("timeout_busy_low", {62'd0, bus.req_busy}, 64'd0);
    @(negedge clk);
    check("timeout_idle", {62'd0, dbg_state}, {62'd0, ST_IDLE});
    clear_err();

    // Reset in the middle of a burst after 20 strobes.
    @(posedge clk);
    #1 bus.req_addr0 = 32'h500;
    bus.req_num0 = 32'd32;
    bus.req_kick = 2'b01;
    wait_kick();
    bus.req_kick = 2'b00;
    repeat (2) @(posedge clk);
    #1 bus.busy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1 bus.buf_we = 1'b1;
      bus.buf_dout = 32'h500 + 32'(i);
      exp_q.push_back({2'b01, 32'h500 + 32'(i)});
    end
    @(posedge clk);
    #1 bus.buf_dout = 32'h0BAD_0000;
    rst = 1'b1;
    #1 check_reset_outputs("async_reset");
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 bus.buf_dout = 32'h0BAD_0001 + 32'(i);
    end
    @(posedge clk);
    #1 bus.buf_we = 1'b0;
    bus.busy = 1'b0;
    @(negedge clk);
    check("post_reset_idle", {62'd0, dbg_state}, {62'd0, ST_IDLE});
    check("post_reset_stray_err", {62'd0, err}, 64'd2);
    clear_err();
    @(posedge clk);
    #1 bus.req_addr0 = 32'h600;
    bus.req_num0 = 32'd3;
    bus.req_kick = 2'b01;
    serve(0, 32'h600, 32'd3, 3, 2'b00);
    repeat (3) @(negedge clk);

    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
